// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
//
// Purpose:
//   Sequences and services the UART receive datapath. It sits between the host
//   register interface and the Rx receiver plus Rx FIFO. It gates the receiver
//   enable so that a character in flight always completes. In non-FIFO mode it
//   captures received characters into a holding register; in FIFO mode it pops
//   the FIFO. It also keeps sticky error and overrun status, runs a
//   character-timeout counter and produces one level interrupt.
//
// Build option:
//   UART_RX_CTRL_TIMEOUT_EN - when defined, the character-timeout counter and
//   timeout_o are built. When undefined, timeout_o is tied to 0 and
//   irq_en_i[1] has no effect.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   baud_en_i            16x oversample tick (timeout time base)
//   rx_en_i              host Rx enable
//   rx_fifo_en_i         host FIFO-mode select
//   rx_done_i            receiver character-complete pulse
//   rx_busy_i            receiver busy
//   rx_parity_err_i      parity error, valid with rx_done_i
//   rx_stop_err_i        stop error, valid with rx_done_i
//   rx_data_i            received character, valid with rx_done_i
//   rx_fifo_full_i       Rx FIFO full
//   rx_fifo_empty_i      Rx FIFO empty
//   rx_fifo_level_i      Rx FIFO fill level
//   rx_fifo_rdata_i      Rx FIFO head data (first-word fall-through)
//   rd_req_i             host read of the data register (1-cycle pulse)
//   status_clr_i         clear the sticky status (1-cycle pulse)
//   irq_en_i             interrupt enables {error, timeout, data}
//   irq_thresh_i         FIFO-mode data interrupt threshold
//   rx_module_en_o       enable to the receiver
//   rx_fifo_pop_o        FIFO pop (combinational from rd_req_i)
//   rd_data_o            read data, valid with rd_valid_o
//   rd_valid_o           read data valid (1 cycle after rd_req_i)
//   data_ready_o         data available to read
//   overrun_o            sticky overrun
//   parity_err_o         sticky parity error
//   stop_err_o           sticky stop error
//   timeout_o            character-timeout flag
//   irq_o                registered interrupt
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
  parameter int unsigned MAX_UART_DATA_W = 8,
  parameter int unsigned FIFO_LEVEL_W    = 5,
  parameter int unsigned TIMEOUT_W       = 10,
  parameter int unsigned TIMEOUT_TICKS   = 640
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       baud_en_i,
  input  logic                       rx_en_i,
  input  logic                       rx_fifo_en_i,
  input  logic                       rx_done_i,
  input  logic                       rx_busy_i,
  input  logic                       rx_parity_err_i,
  input  logic                       rx_stop_err_i,
  input  logic [MAX_UART_DATA_W-1:0] rx_data_i,
  input  logic                       rx_fifo_full_i,
  input  logic                       rx_fifo_empty_i,
  input  logic [FIFO_LEVEL_W-1:0]    rx_fifo_level_i,
  input  logic [MAX_UART_DATA_W-1:0] rx_fifo_rdata_i,
  input  logic                       rd_req_i,
  input  logic                       status_clr_i,
  input  logic [2:0]                 irq_en_i,
  input  logic [FIFO_LEVEL_W-1:0]    irq_thresh_i,
  output logic                       rx_module_en_o,
  output logic                       rx_fifo_pop_o,
  output logic [MAX_UART_DATA_W-1:0] rd_data_o,
  output logic                       rd_valid_o,
  output logic                       data_ready_o,
  output logic                       overrun_o,
  output logic                       parity_err_o,
  output logic                       stop_err_o,
  output logic                       timeout_o,
  output logic                       irq_o
);

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;

  state_e                     state_q;
  logic                       module_en_q;

  logic                       mode_q;
  logic [MAX_UART_DATA_W-1:0] hold_q;
  logic                       data_ready_q;
  logic [MAX_UART_DATA_W-1:0] rd_data_q;
  logic                       rd_valid_q;
  logic                       overrun_q;
  logic                       parity_err_q;
  logic                       stop_err_q;
  logic                       irq_q;

  logic                       timeout_q;
  logic                       timeout_irq;
  logic                       mode_change;
  logic                       fifo_pop;
  logic                       capture;
  logic                       overrun_set;
  logic                       data_cond;
  logic                       err_any;

  // ---------------------------------------------------------------------------
  // Enable FSM: once the host drops rx_en_i, the receiver is held enabled
  // until it reports idle, so the character in flight is not cut short.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_OFF;
      module_en_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          if (rx_en_i) begin
            state_q     <= ST_RUN;
            module_en_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!rx_en_i) begin
            if (rx_busy_i) begin
              state_q     <= ST_STOPPING;
              module_en_q <= 1'b1;
            end else begin
              state_q     <= ST_OFF;
              module_en_q <= 1'b0;
            end
          end
        end
        ST_STOPPING: begin
          if (rx_en_i) begin
            state_q     <= ST_RUN;
            module_en_q <= 1'b1;
          end else if (!rx_busy_i) begin
            state_q     <= ST_OFF;
            module_en_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_OFF;
          module_en_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath control
  // ---------------------------------------------------------------------------
  assign mode_change = (rx_fifo_en_i != mode_q);
  assign fifo_pop    = rx_fifo_en_i & rd_req_i & ~rx_fifo_empty_i;

  // A read in the same cycle frees the holding register, so the new
  // character is captured instead of being flagged as an overrun.
  assign capture     = ~rx_fifo_en_i & rx_done_i & (~data_ready_q | rd_req_i);
  assign overrun_set = rx_done_i & (rx_fifo_en_i ? rx_fifo_full_i
                                                 : (data_ready_q & ~rd_req_i));

  assign data_cond = rx_fifo_en_i ? (rx_fifo_level_i >= irq_thresh_i) : data_ready_q;
  assign err_any   = overrun_q | parity_err_q | stop_err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mode_q       <= 1'b0;
      hold_q       <= '0;
      data_ready_q <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
      stop_err_q   <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      mode_q     <= rx_fifo_en_i;
      rd_valid_q <= rd_req_i;

      // A read with nothing available still completes, returning zero.
      if (rd_req_i) begin
        if (rx_fifo_en_i) begin
          rd_data_q <= fifo_pop ? rx_fifo_rdata_i : '0;
        end else begin
          rd_data_q <= data_ready_q ? hold_q : '0;
        end
      end

      if (mode_change) begin
        hold_q       <= '0;
        data_ready_q <= 1'b0;
      end else if (rx_fifo_en_i) begin
        data_ready_q <= ~rx_fifo_empty_i;
      end else if (capture) begin
        hold_q       <= rx_data_i;
        data_ready_q <= 1'b1;
      end else if (rd_req_i) begin
        data_ready_q <= 1'b0;
      end

      // Sticky flags: a set in the same cycle as a clear wins.
      overrun_q    <= overrun_set | (overrun_q & ~status_clr_i);
      parity_err_q <= (rx_done_i & rx_parity_err_i) | (parity_err_q & ~status_clr_i);
      stop_err_q   <= (rx_done_i & rx_stop_err_i) | (stop_err_q & ~status_clr_i);

      irq_q <= (irq_en_i[2] & err_any) | timeout_irq | (irq_en_i[0] & data_cond);
    end
  end

  // ---------------------------------------------------------------------------
  // Character timeout
  // ---------------------------------------------------------------------------
`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TimeoutLast = TIMEOUT_W'(TIMEOUT_TICKS - 1);

  logic [TIMEOUT_W-1:0] to_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (!data_ready_q || rx_done_i || rd_req_i) begin
        to_cnt_q <= '0;
      end else if (baud_en_i && !rx_busy_i && (to_cnt_q != TimeoutLast)) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end

      if (!data_ready_q || rd_req_i) begin
        timeout_q <= 1'b0;
      end else if (to_cnt_q == TimeoutLast) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_irq = irq_en_i[1] & timeout_q;
`else
  logic unused_timeout_cfg;

  assign timeout_q          = 1'b0;
  assign timeout_irq        = 1'b0;
  assign unused_timeout_cfg = irq_en_i[1] ^ baud_en_i ^ (TIMEOUT_W == 0) ^ (TIMEOUT_TICKS == 0);
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rx_module_en_o = module_en_q;
  assign rx_fifo_pop_o  = fifo_pop;
  assign rd_data_o      = rd_data_q;
  assign rd_valid_o     = rd_valid_q;
  assign data_ready_o   = data_ready_q;
  assign overrun_o      = overrun_q;
  assign parity_err_o   = parity_err_q;
  assign stop_err_o     = stop_err_q;
  assign timeout_o      = timeout_q;
  assign irq_o          = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
//
// Directed self-checking bench for uart_rx_ctrl. Inputs are driven 1 time unit
// after the rising edge and outputs are checked at the same point, before the
// next stimulus change. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic       clk_i;
  logic       rst_ni;
  logic       baud_en_i;
  logic       rx_en_i;
  logic       rx_fifo_en_i;
  logic       rx_done_i;
  logic       rx_busy_i;
  logic       rx_parity_err_i;
  logic       rx_stop_err_i;
  logic [7:0] rx_data_i;
  logic       rx_fifo_full_i;
  logic       rx_fifo_empty_i;
  logic [4:0] rx_fifo_level_i;
  logic [7:0] rx_fifo_rdata_i;
  logic       rd_req_i;
  logic       status_clr_i;
  logic [2:0] irq_en_i;
  logic [4:0] irq_thresh_i;
  logic       rx_module_en_o;
  logic       rx_fifo_pop_o;
  logic [7:0] rd_data_o;
  logic       rd_valid_o;
  logic       data_ready_o;
  logic       overrun_o;
  logic       parity_err_o;
  logic       stop_err_o;
  logic       timeout_o;
  logic       irq_o;

  int checks   = 0;
  int failures = 0;

  uart_rx_ctrl #(
    .MAX_UART_DATA_W(8),
    .FIFO_LEVEL_W   (5),
    .TIMEOUT_W      (10),
    .TIMEOUT_TICKS  (640)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .baud_en_i      (baud_en_i),
    .rx_en_i        (rx_en_i),
    .rx_fifo_en_i   (rx_fifo_en_i),
    .rx_done_i      (rx_done_i),
    .rx_busy_i      (rx_busy_i),
    .rx_parity_err_i(rx_parity_err_i),
    .rx_stop_err_i  (rx_stop_err_i),
    .rx_data_i      (rx_data_i),
    .rx_fifo_full_i (rx_fifo_full_i),
    .rx_fifo_empty_i(rx_fifo_empty_i),
    .rx_fifo_level_i(rx_fifo_level_i),
    .rx_fifo_rdata_i(rx_fifo_rdata_i),
    .rd_req_i       (rd_req_i),
    .status_clr_i   (status_clr_i),
    .irq_en_i       (irq_en_i),
    .irq_thresh_i   (irq_thresh_i),
    .rx_module_en_o (rx_module_en_o),
    .rx_fifo_pop_o  (rx_fifo_pop_o),
    .rd_data_o      (rd_data_o),
    .rd_valid_o     (rd_valid_o),
    .data_ready_o   (data_ready_o),
    .overrun_o      (overrun_o),
    .parity_err_o   (parity_err_o),
    .stop_err_o     (stop_err_o),
    .timeout_o      (timeout_o),
    .irq_o          (irq_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_en"},      32'(rx_module_en_o), 32'h0);
    check({tag, "_pop"},     32'(rx_fifo_pop_o),  32'h0);
    check({tag, "_rdata"},   32'(rd_data_o),      32'h0);
    check({tag, "_rvalid"},  32'(rd_valid_o),     32'h0);
    check({tag, "_dready"},  32'(data_ready_o),   32'h0);
    check({tag, "_ovr"},     32'(overrun_o),      32'h0);
    check({tag, "_par"},     32'(parity_err_o),   32'h0);
    check({tag, "_stop"},    32'(stop_err_o),     32'h0);
    check({tag, "_timeout"}, 32'(timeout_o),      32'h0);
    check({tag, "_irq"},     32'(irq_o),          32'h0);
  endtask

  initial begin
    rst_ni = 1'b0;          baud_en_i = 1'b0;       rx_en_i = 1'b0;
    rx_fifo_en_i = 1'b0;    rx_done_i = 1'b0;       rx_busy_i = 1'b0;
    rx_parity_err_i = 1'b0; rx_stop_err_i = 1'b0;   rx_data_i = 8'h00;
    rx_fifo_full_i = 1'b0;  rx_fifo_empty_i = 1'b1; rx_fifo_level_i = 5'd0;
    rx_fifo_rdata_i = 8'h00; rd_req_i = 1'b0;       status_clr_i = 1'b0;
    irq_en_i = 3'b000;      irq_thresh_i = 5'd0;

    // Reset state
    tick(); tick();
    check_all_zero("reset");

    // Enable
    rst_ni = 1'b1; rx_en_i = 1'b1;
    tick();
    check("en_on", 32'(rx_module_en_o), 32'h1);

    // Non-FIFO capture of 0xA5 and read-back
    rx_data_i = 8'hA5; rx_done_i = 1'b1;
    tick();
    rx_done_i = 1'b0;
    check("cap_dready", 32'(data_ready_o), 32'h1);
    check("cap_ovr",    32'(overrun_o),    32'h0);
    rd_req_i = 1'b1;
    tick();
    rd_req_i = 1'b0;
    check("cap_rvalid", 32'(rd_valid_o),   32'h1);
    check("cap_rdata",  32'(rd_data_o),    32'hA5);
    check("cap_dready0", 32'(data_ready_o), 32'h0);
    tick();
    check("cap_rvalid_pulse", 32'(rd_valid_o), 32'h0);

    // Overrun: 0x11 then 0x22 with no read
    rx_data_i = 8'h11; rx_done_i = 1'b1;
    tick();
    rx_data_i = 8'h22;
    tick();
    rx_done_i = 1'b0;
    check("ovr_set",    32'(overrun_o),    32'h1);
    check("ovr_dready", 32'(data_ready_o), 32'h1);
    rd_req_i = 1'b1;
    tick();
    rd_req_i = 1'b0;
    check("ovr_rdata",  32'(rd_data_o),    32'h11);
    check("ovr_dready0", 32'(data_ready_o), 32'h0);
    status_clr_i = 1'b1;
    tick();
    status_clr_i = 1'b0;
    check("ovr_clr", 32'(overrun_o), 32'h0);

    // Empty read in non-FIFO mode
    rd_req_i = 1'b1;
    tick();
    rd_req_i = 1'b0;
    check("empty_rvalid", 32'(rd_valid_o), 32'h1);
    check("empty_rdata",  32'(rd_data_o),  32'h0);

    // Simultaneous done+parity, status clear and read
    rx_data_i = 8'h33; rx_done_i = 1'b1;
    tick();
    rx_data_i = 8'h44; rx_parity_err_i = 1'b1; status_clr_i = 1'b1; rd_req_i = 1'b1;
    tick();
    rx_done_i = 1'b0; rx_parity_err_i = 1'b0; status_clr_i = 1'b0; rd_req_i = 1'b0;
    check("sim_par",    32'(parity_err_o), 32'h1);
    check("sim_rdata",  32'(rd_data_o),    32'h33);
    check("sim_rvalid", 32'(rd_valid_o),   32'h1);
    check("sim_dready", 32'(data_ready_o), 32'h1);
    check("sim_ovr",    32'(overrun_o),    32'h0);
    rd_req_i = 1'b1;
    tick();
    rd_req_i = 1'b0;
    check("sim_newdata", 32'(rd_data_o), 32'h44);

    // Stop error and error interrupt
    irq_en_i = 3'b100;
    rx_data_i = 8'h55; rx_done_i = 1'b1; rx_stop_err_i = 1'b1;
    tick();
    rx_done_i = 1'b0; rx_stop_err_i = 1'b0;
    check("stop_set", 32'(stop_err_o), 32'h1);
    tick();
    check("err_irq", 32'(irq_o), 32'h1);
    status_clr_i = 1'b1;
    tick();
    status_clr_i = 1'b0;
    check("err_clr_par",  32'(parity_err_o), 32'h0);
    check("err_clr_stop", 32'(stop_err_o),   32'h0);
    tick();
    check("err_irq_off", 32'(irq_o), 32'h0);
    rd_req_i = 1'b1;
    tick();
    rd_req_i = 1'b0;
    check("stop_rdata", 32'(rd_data_o), 32'h55);
    irq_en_i = 3'b000;

    // FIFO mode: threshold interrupt
    rx_fifo_en_i = 1'b1; irq_en_i = 3'b001; irq_thresh_i = 5'd4;
    tick(); tick();
    check("fifo_dready0", 32'(data_ready_o), 32'h0);
    check("fifo_irq0",    32'(irq_o),        32'h0);
    rx_fifo_empty_i = 1'b0; rx_fifo_level_i = 5'd1;
    tick();
    rx_fifo_level_i = 5'd2;
    tick();
    rx_fifo_level_i = 5'd3;
    tick();
    check("fifo_irq_lvl3", 32'(irq_o),        32'h0);
    check("fifo_dready",   32'(data_ready_o), 32'h1);
    rx_fifo_level_i = 5'd4;
    tick();
    check("fifo_irq_lvl4", 32'(irq_o), 32'h1);
    rx_fifo_rdata_i = 8'h7E; rd_req_i = 1'b1;
    #1;
    check("fifo_pop", 32'(rx_fifo_pop_o), 32'h1);
    tick();
    rd_req_i = 1'b0;
    #1;
    check("fifo_pop_pulse", 32'(rx_fifo_pop_o), 32'h0);
    check("fifo_rvalid",    32'(rd_valid_o),    32'h1);
    check("fifo_rdata",     32'(rd_data_o),     32'h7E);
    rx_fifo_level_i = 5'd3;
    tick();
    check("fifo_irq_drop", 32'(irq_o), 32'h0);

    // FIFO overrun, set beats clear
    rx_fifo_full_i = 1'b1; rx_done_i = 1'b1;
    tick();
    rx_done_i = 1'b0;
    check("fifo_ovr", 32'(overrun_o), 32'h1);
    rx_done_i = 1'b1; status_clr_i = 1'b1;
    tick();
    rx_done_i = 1'b0; status_clr_i = 1'b0;
    check("set_wins", 32'(overrun_o), 32'h1);
    status_clr_i = 1'b1;
    tick();
    status_clr_i = 1'b0; rx_fifo_full_i = 1'b0;
    check("fifo_ovr_clr", 32'(overrun_o), 32'h0);

    // FIFO empty read
    rx_fifo_empty_i = 1'b1; rx_fifo_level_i = 5'd0; rd_req_i = 1'b1;
    #1;
    check("fifo_empty_nopop", 32'(rx_fifo_pop_o), 32'h0);
    tick();
    rd_req_i = 1'b0;
    check("fifo_empty_rvalid", 32'(rd_valid_o),   32'h1);
    check("fifo_empty_rdata",  32'(rd_data_o),    32'h0);
    check("fifo_empty_dready", 32'(data_ready_o), 32'h0);

    // Mode change clears data but keeps sticky flags
    irq_en_i = 3'b000; rx_fifo_en_i = 1'b0;
    tick();
    rx_data_i = 8'h66; rx_done_i = 1'b1; rx_parity_err_i = 1'b1;
    tick();
    rx_done_i = 1'b0; rx_parity_err_i = 1'b0;
    check("mode_cap", 32'(data_ready_o), 32'h1);
    rx_fifo_en_i = 1'b1; rx_fifo_empty_i = 1'b0;
    tick();
    check("mode_dready_clr", 32'(data_ready_o), 32'h0);
    check("mode_par_kept",   32'(parity_err_o), 32'h1);
    rx_fifo_en_i = 1'b0; rx_fifo_empty_i = 1'b1;
    tick();
    rd_req_i = 1'b1;
    tick();
    rd_req_i = 1'b0;
    check("mode_rdata", 32'(rd_data_o), 32'h0);
    status_clr_i = 1'b1;
    tick();
    status_clr_i = 1'b0;

    // Graceful disable: receiver busy keeps enable until character completes
    rx_busy_i = 1'b1; rx_en_i = 1'b0;
    tick();
    check("stopping_en", 32'(rx_module_en_o), 32'h1);
    tick();
    check("stopping_en2", 32'(rx_module_en_o), 32'h1);
    rx_data_i = 8'h5A; rx_done_i = 1'b1;
    tick();
    rx_done_i = 1'b0; rx_busy_i = 1'b0;
    tick();
    check("stop_off",    32'(rx_module_en_o), 32'h0);
    check("stop_dready", 32'(data_ready_o),   32'h1);
    rd_req_i = 1'b1;
    tick();
    rd_req_i = 1'b0;
    check("stop_rdata", 32'(rd_data_o), 32'h5A);

    // STOPPING -> RUN when rx_en_i returns, RUN -> OFF when idle
    rx_en_i = 1'b1;
    tick();
    rx_busy_i = 1'b1; rx_en_i = 1'b0;
    tick();
    rx_en_i = 1'b1;
    tick();
    rx_busy_i = 1'b0;
    tick();
    check("resume_run", 32'(rx_module_en_o), 32'h1);
    rx_en_i = 1'b0;
    tick();
    check("run_off", 32'(rx_module_en_o), 32'h0);

    // Character timeout
    rx_en_i = 1'b1; irq_en_i = 3'b010;
    rx_data_i = 8'h77; rx_done_i = 1'b1;
    tick();
    rx_done_i = 1'b0; baud_en_i = 1'b1;
    repeat (639) tick();
    check("timeout_639", 32'(timeout_o), 32'h0);
    tick();
    check("timeout_640", 32'(timeout_o), 32'(TO_EN));
    tick();
    check("timeout_hold", 32'(timeout_o), 32'(TO_EN));
    check("timeout_irq",  32'(irq_o),     32'(TO_EN));
    rd_req_i = 1'b1;
    tick();
    rd_req_i = 1'b0; baud_en_i = 1'b0;
    check("timeout_clr",   32'(timeout_o), 32'h0);
    check("timeout_rdata", 32'(rd_data_o), 32'h77);

    // Reset mid-character
    irq_en_i = 3'b111;
    rx_data_i = 8'h12; rx_done_i = 1'b1; rx_parity_err_i = 1'b1;
    tick();
    rx_done_i = 1'b0; rx_parity_err_i = 1'b0;
    tick();
    check("pre_rst_irq", 32'(irq_o), 32'h1);
    rx_busy_i = 1'b1; rst_ni = 1'b0;
    tick();
    check_all_zero("midrst");
    rst_ni = 1'b1; rx_busy_i = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

- Sequences and services the UART receive datapath. Sits between the host register interface and the Rx receiver plus Rx FIFO.
- Gates receiver enable so a character in flight always completes.
- Captures received characters into a holding register (non-FIFO mode) or pops the FIFO (FIFO mode).
- Keeps sticky error/overrun status, runs a character-timeout counter, and produces one level interrupt.

## Interface

Parameters:
- MAX_UART_DATA_W, 8, width of UART data
- FIFO_LEVEL_W, 5, width of Rx FIFO fill-level input
- TIMEOUT_W, 10, width of character-timeout counter
- TIMEOUT_TICKS, 640, baud_en_i ticks of idle line before timeout (4 chars × 10 bits × 16)

Ports:
- clk_i  in  1  top clock
- rst_ni  in  1  reset; synchronous, active-low
- baud_en_i  in  1  16× oversample tick
- rx_en_i  in  1  host Rx enable
- rx_fifo_en_i  in  1  host FIFO-mode select
- rx_done_i  in  1  receiver character-complete pulse
- rx_busy_i  in  1  receiver busy
- rx_parity_err_i  in  1  receiver parity error, valid with rx_done_i
- rx_stop_err_i  in  1  receiver stop error, valid with rx_done_i
- rx_data_i  in  MAX_UART_DATA_W  receiver data, valid with rx_done_i
- rx_fifo_full_i  in  1  FIFO full
- rx_fifo_empty_i  in  1  FIFO empty
- rx_fifo_level_i  in  FIFO_LEVEL_W  FIFO fill level
- rx_fifo_rdata_i  in  MAX_UART_DATA_W  FIFO head data, first-word-fall-through
- rd_req_i  in  1  host read of data register, 1-cycle pulse
- status_clr_i  in  1  clear sticky status, 1-cycle pulse
- irq_en_i  in  3  interrupt enables {error, timeout, data}
- irq_thresh_i  in  FIFO_LEVEL_W  FIFO-mode data interrupt threshold
- rx_module_en_o  out  1  enable to receiver
- rx_fifo_pop_o  out  1  FIFO pop, 1 cycle
- rd_data_o  out  MAX_UART_DATA_W  read data
- rd_valid_o  out  1  read data valid, 1 cycle
- data_ready_o  out  1  data available to read
- overrun_o  out  1  sticky overrun
- parity_err_o  out  1  sticky parity error
- stop_err_o  out  1  sticky stop error
- timeout_o  out  1  character timeout flag
- irq_o  out  1  registered interrupt

## Operation

**Reset.** All outputs are 0 and the FSM is in OFF. Asserting reset mid-character abandons the character and clears the holding register and all flags.

**Enable FSM.** rx_module_en_o = 1 in RUN and STOPPING.
- OFF → RUN when rx_en_i = 1.
- RUN → OFF when rx_en_i = 0 and rx_busy_i = 0.
- RUN → STOPPING when rx_en_i = 0 and rx_busy_i = 1.
- STOPPING → OFF when rx_busy_i = 0.
- STOPPING → RUN when rx_en_i returns to 1.
- rx_done_i is still serviced in STOPPING.

**Non-FIFO mode** (rx_fifo_en_i = 0):
- On rx_done_i, the holding register is loaded with rx_data_i and data_ready_o is set.
- If data_ready_o is already 1 and no rd_req_i arrives in the same cycle: the new character is dropped and overrun_o is set.
- rd_req_i returns the holding register with rd_valid_o and clears data_ready_o.
- rx_done_i and rd_req_i in the same cycle: the read returns the old data, the new data is captured, data_ready_o stays 1, and there is no overrun.

**FIFO mode** (rx_fifo_en_i = 1):
- rx_done_i with rx_fifo_full_i = 1 sets overrun_o, because the receiver does not push when the FIFO is full.
- rd_req_i with FIFO not empty: rx_fifo_pop_o is pulsed and rx_fifo_rdata_i is registered to rd_data_o.
- data_ready_o = ~rx_fifo_empty_i, registered.

**Empty read.** A read in either mode with no data gives rd_valid_o = 1, rd_data_o = 0, and no pop.

**Errors.**
- parity_err_o and stop_err_o set on rx_done_i when the matching input is high.
- Every sticky flag clears on status_clr_i.
- If a set and a clear occur in the same cycle, the set wins.

**Timeout.**
- The counter increments on baud_en_i while all of these hold: data is available, rx_busy_i = 0, no rd_req_i.
- The counter resets to 0 on rx_done_i, rd_req_i, or when no data is available.
- timeout_o sets when the count reaches TIMEOUT_TICKS-1, and the counter saturates there.
- timeout_o clears on rd_req_i or when data becomes unavailable.

**Interrupt.** irq_o is the registered OR of:
- irq_en_i[2] & (overrun | parity | stop)
- irq_en_i[1] & timeout_o
- irq_en_i[0] & data condition, where the data condition is data_ready_o in non-FIFO mode and rx_fifo_level_i >= irq_thresh_i in FIFO mode.

**Mode change.** Changing rx_fifo_en_i clears the holding register and data_ready_o, and leaves the sticky flags unchanged.

## Timing

- rd_req_i at cycle N gives rd_valid_o and rd_data_o at N+1. rx_fifo_pop_o is asserted at N, combinational from rd_req_i & ~rx_fifo_empty_i.
- rx_done_i at N: data_ready_o, error flags and overrun_o update at N+1.
- irq_o lags its sources by 1 cycle.
- rx_module_en_o changes 1 cycle after the FSM transition condition.
- rd_req_i must not be reasserted before rd_valid_o; back-to-back pulses on alternate cycles are legal.

## Configuration

Macro: UART_RX_CTRL_TIMEOUT_EN.
- **Defined:** the timeout counter and timeout_o logic are compiled in.
- **Undefined:** no counter is built, timeout_o is tied to 0, irq_en_i[1] is ignored, and TIMEOUT_W and TIMEOUT_TICKS are unused.

## Test plan

- **Non-FIFO capture:** rx_done_i with data 0xA5, then rd_req_i → rd_valid_o and rd_data_o = 0xA5 next cycle; data_ready_o 1 → 0; overrun_o = 0.
- **Overrun:** two rx_done_i pulses (0x11, then 0x22) with no read → overrun_o = 1; read returns 0x11; status_clr_i → overrun_o = 0.
- **FIFO threshold IRQ:** irq_en_i = 3'b001, irq_thresh_i = 4, four pushes → irq_o = 1 one cycle after level = 4; a read pops once and level 3 → irq_o = 0.
- **Graceful disable:** drop rx_en_i while rx_busy_i = 1 → rx_module_en_o stays 1 until rx_busy_i falls; the final rx_done_i (0x5A) is captured.
- **Timeout** (macro defined, TIMEOUT_TICKS = 640): one character held, line idle → timeout_o = 1 after 640 baud_en_i ticks; rd_req_i clears it. With the macro undefined, timeout_o stays 0.
- **Simultaneous events:** rx_done_i with parity error, status_clr_i and rd_req_i in the same cycle → parity_err_o = 1, old data returned, new data held, overrun_o = 0. rst_ni low mid-character → all outputs 0 the next cycle.
